// File: rtl/seq_mult_ctrl_if.sv
// Operand/result handshake bundle for seq_mult_ctrl.
//   start      : request a multiply (requester -> controller)
//   dataa/b    : 8-bit operands, sampled with an accepted start
//   busy       : controller is stepping through partial products
//   done_flag  : one-cycle pulse, product valid
//   product    : last completed 16-bit result
interface seq_mult_ctrl_if;
  logic        start;
  logic [7:0]  dataa;
  logic [7:0]  datab;
  logic        busy;
  logic        done_flag;
  logic [15:0] product;

  modport master (
    output start, dataa, datab,
    input  busy, done_flag, product
  );

  modport slave (
    input  start, dataa, datab,
    output busy, done_flag, product
  );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Sequencing controller and accumulator for the 8x8 sequential multiplier.
// Captures operands on start, walks the four nibble partial products
// (lo*lo, hi*lo<<4, lo*hi<<4, hi*hi<<8), accumulates into 16 bits and
// pulses done_flag in the cycle the new product is valid.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : operand/result handshake (slave side)
//   sel_a      : dataa nibble select (0 = [3:0], 1 = [7:4])
//   sel_b      : datab nibble select, same encoding
//   shift_sel  : partial-product shift (0 = <<0, 1 = <<4, 2 = <<8)
module seq_mult_ctrl (
  input  logic                  clk,
  input  logic                  reset,
  seq_mult_ctrl_if.slave        bus,
  output logic                  sel_a,
  output logic                  sel_b,
  output logic [1:0]            shift_sel
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [1:0]  cnt;
  logic [7:0]  ra;
  logic [7:0]  rb;
  logic [15:0] acc;
  logic [15:0] product_q;
  logic        busy_d;
  logic        done_d;
  logic        capture;
  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic [7:0]  pp;
  logic [15:0] pp_shifted;
  logic [15:0] sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Outputs are decoded from registered state/cnt only, so start never
  // reaches an output combinationally.
  always_comb begin
    next_state = state;
    sel_a      = 1'b0;
    sel_b      = 1'b0;
    shift_sel  = 2'd0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) next_state = CALC;
      end
      CALC: begin
        busy_d = 1'b1;
        case (cnt)
          2'd0: begin sel_a = 1'b0; sel_b = 1'b0; shift_sel = 2'd0; end
          2'd1: begin sel_a = 1'b1; sel_b = 1'b0; shift_sel = 2'd1; end
          2'd2: begin sel_a = 1'b0; sel_b = 1'b1; shift_sel = 2'd1; end
          default: begin sel_a = 1'b1; sel_b = 1'b1; shift_sel = 2'd2; end
        endcase
        if (cnt == 2'd3) next_state = DONE;
      end
      DONE: begin
        done_d     = 1'b1;
        next_state = bus.start ? CALC : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign capture = bus.start && ((state == IDLE) || (state == DONE));

  assign a_nib = sel_a ? ra[7:4] : ra[3:0];
  assign b_nib = sel_b ? rb[7:4] : rb[3:0];
  assign pp    = a_nib * b_nib;

  always_comb begin
    pp_shifted = '0;
    case (shift_sel)
      2'd0:    pp_shifted = {8'h00, pp};
      2'd1:    pp_shifted = {4'h0, pp, 4'h0};
      2'd2:    pp_shifted = {pp, 8'h00};
      default: pp_shifted = '0;
    endcase
  end

  assign sum = acc + pp_shifted;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      ra        <= '0;
      rb        <= '0;
      acc       <= '0;
      product_q <= '0;
    end else if (capture) begin
      ra  <= bus.dataa;
      rb  <= bus.datab;
      acc <= '0;
      cnt <= '0;
    end else if (state == CALC) begin
      acc <= sum;
      cnt <= cnt + 2'd1;
      // Final step: publish the completed sum directly, acc is stale next.
      if (cnt == 2'd3) product_q <= sum;
    end
  end

  assign bus.busy      = busy_d;
  assign bus.done_flag = done_d;
  assign bus.product   = product_q;

endmodule

// File: doc/seq_mult_ctrl.md
# seq_mult_ctrl

Sequencing controller and accumulator for the 8x8 sequential multiplier. It captures two 8-bit operands on a start strobe and steps the shared 4-bit nibble muxes and the 4x4 partial-product path through four cycles. It shift-accumulates the partial products into a 16-bit result and reports completion with a one-cycle done pulse. It sits between the top-level operand and result interface and the nibble-select mux4 instances.

## Interface

- No parameters. Operand width is fixed at 8; the nibble width is fixed at 4.
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE and DONE
- dataa  input  8  multiplicand; sampled in the start cycle only
- datab  input  8  multiplier; sampled in the start cycle only
- sel_a  output  1  mux select for the dataa nibble: 0 = low nibble [3:0], 1 = high nibble [7:4]
- sel_b  output  1  mux select for the datab nibble, same encoding as sel_a
- shift_sel  output  2  partial-product shift: 0 = <<0, 1 = <<4, 2 = <<8; 3 is never driven
- busy  output  1  high while in CALC
- done_flag  output  1  one-cycle pulse marking the cycle in which a new product is valid
- product  output  16  last completed result; holds until the next completion

## Operation

- The FSM has three states: IDLE, CALC and DONE. It also has a 2-bit step counter `cnt`, operand registers `ra`/`rb` (8 bits each) and a 16-bit accumulator `acc`.
- IDLE, start=1: latch dataa and datab into ra and rb, clear acc to 0, set cnt=0, go to CALC.
- IDLE, start=0: stay in IDLE.
- CALC, each cycle:
  - Form the nibble product pp from the selected ra and rb nibbles.
  - Update acc <= acc + (pp << shift), with the sum truncated to 16 bits. The true maximum is 0xFE01, so no overflow occurs.
  - Then cnt <= cnt+1.
- Step table for CALC, given as (sel_a, sel_b, shift_sel):
  - cnt=0: (0, 0, 0), which is a_lo*b_lo
  - cnt=1: (1, 0, 1), which is a_hi*b_lo<<4
  - cnt=2: (0, 1, 1), which is a_lo*b_hi<<4
  - cnt=3: (1, 1, 2), which is a_hi*b_hi<<8
- CALC with cnt=3: load product <= acc + (pp<<8), the final sum, and go to DONE.
- DONE lasts exactly one cycle; done_flag=1 during it.
  - start=1 in DONE: behave as IDLE with start=1. Capture new operands and go to CALC for back-to-back operation.
  - start=0 in DONE: go to IDLE.
- start in CALC is ignored. dataa and datab changes after the start cycle have no effect.
- In IDLE and DONE: sel_a=0, sel_b=0, shift_sel=0.
- busy=1 exactly when the state is CALC.
- Outputs are decoded from registered state (state, cnt). There is no combinational path from start to any output.

## Timing

- Reset values:
  - state=IDLE, cnt=0, ra=0, rb=0, acc=0
  - product=0x0000, done_flag=0, busy=0, sel_a=0, sel_b=0, shift_sel=0
- Start is accepted at edge E0.
  - CALC occupies the cycles after edges E0, E1, E2 and E3.
  - DONE occupies the cycle after edge E4.
  - Latency from the accepting edge to the cycle in which done_flag is high is 4 cycles.
  - product changes at edge E4 and is valid in the done_flag cycle.
- Back-to-back throughput: one result every 5 cycles, with start held or pulsed in DONE.
- product is stable throughout CALC. It shows the previous result and is updated only at the final CALC edge.
- Reset asserted mid-CALC:
  - Immediate return to the reset values, including product=0.
  - No done_flag pulse.
  - After reset deasserts, the FSM waits in IDLE for a fresh start.
- start held high continuously: one operation per 5 cycles. Operands are re-sampled at each DONE-state edge.

## Test plan

- Reset, then dataa=0x12, datab=0x34, start for 1 cycle -> busy=1 for 4 cycles; sel_a/sel_b/shift_sel follow 00/0, 10/1, 01/1, 11/2; then done_flag=1 for 1 cycle with product=0x03A8.
- dataa=0xFF, datab=0xFF -> product=0xFE01 after 4 CALC cycles. Also dataa=0x00, datab=0xA5 -> product=0x0000 with done_flag still pulsed.
- Start with 0x0F*0x10. Two cycles later, pulse start with 0xFF*0xFF and change dataa/datab -> second start ignored; product=0x00F0; only one done_flag pulse.
- start held high with 0x03*0x05 then 0x10*0x10 presented at DONE -> done pulses 5 cycles apart; products 0x000F then 0x0100.
- After a completed 0x12*0x34 (product=0x03A8), start 0xFF*0xFF and assert reset at the second CALC cycle -> all outputs return to reset values immediately; no done_flag; a subsequent 0x02*0x03 gives product=0x0006.
- Idle check -> during CALC, product holds the previous value each cycle; in IDLE, done_flag=0 and selects=0 for 20+ cycles with start=0.
